logic_unit_checker: RTL and testbench

Response checker for the 8-bit bitwise logic units of the ALU (AND/OR/XOR/NOR). It consumes operand/result beats from a stimulus source and recomputes the expected result of the selected operation. It counts vectors and mismatches, latches the first failing vector and folds every result into a MISR signature. It is the receiving end of the stimulus stream: the stimulus driver or BIST sequencer drives a, b and the unit's output; this block judges them and reports pass/fail.

---
 rtl/logic_unit_checker.sv | 123 ++++++++++++
 tb/tb_logic_unit_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_checker.sv
// logic_unit_checker: response checker for the ALU bitwise logic units.
// Recomputes each result, counts beats/errors, keeps first fault, MISR.
module logic_unit_checker #(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 16,
  parameter logic [WIDTH-1:0] MISR_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_SEED = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             vld,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] misr_nxt;
  logic             mismatch;
  logic             vec_sat;
  logic             err_sat;
  logic             no_err;

  // expected result of the operation latched at start
  always_comb begin
    exp_val = '0;
    case (op_q)
      2'b00:   exp_val = a & b;
      2'b01:   exp_val = a | b;
      2'b10:   exp_val = a ^ b;
      2'b11:   exp_val = ~(a | b);
      default: exp_val = '0;
    endcase
  end

  assign mismatch = (dut_out != exp_val);
  assign vec_sat  = &vec_cnt;
  assign err_sat  = &err_cnt;
  assign no_err   = (err_cnt == '0);

  assign misr_nxt =
    {signature[WIDTH-2:0], ^(signature & MISR_TAPS)} ^ dut_out;

  assign pass = done && no_err && (vec_cnt != '0);

  // run control, beat checking, first-fault capture and signature
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= 2'b00;
      busy          <= 1'b0;
      done          <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
      signature     <= MISR_SEED;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            op_q          <= op;
            busy          <= 1'b1;
            done          <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            signature     <= MISR_SEED;
          end
        end
        RUN: begin
          if (vld) begin
            if (!vec_sat) vec_cnt <= vec_cnt + CNT_W'(1);
            signature <= misr_nxt;
            if (mismatch) begin
              if (!err_sat) err_cnt <= err_cnt + CNT_W'(1);
              if (no_err) begin
                first_err_idx <= vec_cnt;
                first_err_exp <= exp_val;
                first_err_got <= dut_out;
              end
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_checker.sv
// tb_logic_unit_checker: directed plus random runs against a
// behavioural run model; a second instance exercises saturation.
module tb_logic_unit_checker;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic       vld = 1'b0;
  logic       last = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] dut_out = '0;

  logic        busy, done, pass;
  logic [15:0] vec_cnt, err_cnt, first_err_idx;
  logic [7:0]  first_err_exp, first_err_got, signature;

  logic       s_busy, s_done, s_pass;
  logic [3:0] s_vec, s_err, s_fidx;
  logic [7:0] s_fexp, s_fgot, s_sig;

  int checks = 0;
  int failures = 0;

  // model: run phase and unbounded run statistics
  bit         m_run, m_done;
  logic [1:0] m_op;
  int         m_vec, m_err, m_fidx;
  logic [7:0] m_fexp, m_fgot, m_sig;

  always #5 clk = ~clk;

  logic_unit_checker #(
    .WIDTH(8), .CNT_W(16), .MISR_TAPS(TAPS), .MISR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .vld(vld), .last(last), .a(a), .b(b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp),
    .first_err_got(first_err_got),
    .signature(signature)
  );

  logic_unit_checker #(
    .WIDTH(8), .CNT_W(4), .MISR_TAPS(TAPS), .MISR_SEED(SEED)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .vld(vld), .last(last), .a(a), .b(b), .dut_out(dut_out),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .vec_cnt(s_vec), .err_cnt(s_err),
    .first_err_idx(s_fidx),
    .first_err_exp(s_fexp),
    .first_err_got(s_fgot),
    .signature(s_sig)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] o,
                                        input logic [7:0] x,
                                        input logic [7:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] s,
                                      input logic [7:0] d);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 8; i++)
      if (TAPS[i]) fb = fb ^ s[i];
    return ((s << 1) | {7'd0, fb}) ^ d;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_edge();
    logic [7:0] e;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_op = 0;
      m_vec = 0; m_err = 0; m_fidx = 0;
      m_fexp = 0; m_fgot = 0; m_sig = SEED;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_op = op;
        m_vec = 0; m_err = 0; m_fidx = 0;
        m_fexp = 0; m_fgot = 0; m_sig = SEED;
      end
    end else if (vld) begin
      e = ref_op(m_op, a, b);
      if (dut_out != e) begin
        if (m_err == 0) begin
          m_fidx = m_vec; m_fexp = e; m_fgot = dut_out;
        end
        m_err++;
      end
      m_vec++;
      m_sig = misr(m_sig, dut_out);
      if (last) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic check_all();
    bit p16, p4;
    p16 = m_done && m_err == 0 && m_vec != 0;
    p4  = p16;
    check("busy", 32'(busy), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("pass", 32'(pass), 32'(p16));
    check("vec_cnt", 32'(vec_cnt), sat(m_vec, 16));
    check("err_cnt", 32'(err_cnt), sat(m_err, 16));
    check("first_err_idx", 32'(first_err_idx), sat(m_fidx, 16));
    check("first_err_exp", 32'(first_err_exp), 32'(m_fexp));
    check("first_err_got", 32'(first_err_got), 32'(m_fgot));
    check("signature", 32'(signature), 32'(m_sig));
    check("s_busy", 32'(s_busy), 32'(m_run));
    check("s_done", 32'(s_done), 32'(m_done));
    check("s_pass", 32'(s_pass), 32'(p4));
    check("s_vec_cnt", 32'(s_vec), sat(m_vec, 4));
    check("s_err_cnt", 32'(s_err), sat(m_err, 4));
    check("s_first_err_idx", 32'(s_fidx), sat(m_fidx, 4));
    check("s_signature", 32'(s_sig), 32'(m_sig));
  endtask

  task automatic cyc(input bit r, input bit st, input logic [1:0] o,
                     input bit v, input bit l, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] d);
    @(negedge clk);
    rst_n = r; start = st; op = o; vld = v; last = l;
    a = x; b = y; dut_out = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic beat(input bit l, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] d);
    cyc(1, 0, 2'd0, 1, l, x, y, d);
  endtask

  task automatic go(input logic [1:0] o);
    cyc(1, 1, o, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic idle();
    cyc(1, 0, 2'd0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic rand_run(input int n);
    logic [1:0] o;
    logic [7:0] x, y, e, d;
    o = 2'($urandom_range(0, 3));
    cyc(1, 1, o, 1'($urandom_range(0, 1)), 1,
        8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0)
        cyc(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            0, 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 8'($urandom));
      x = 8'($urandom); y = 8'($urandom);
      e = ref_op(o, x, y);
      d = ($urandom_range(0, 3) == 0) ?
          e ^ 8'($urandom_range(1, 255)) : e;
      cyc(1, 1'($urandom_range(0, 1)), ~o, 1, i == n - 1, x, y, d);
    end
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 2'd0, 1'($urandom_range(0, 1)), 1,
          8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    // reset with start and vld asserted
    cyc(0, 1, 2'd1, 1, 1, 8'hFF, 8'hFF, 8'h12);
    cyc(0, 1, 2'd1, 1, 1, 8'hFF, 8'hFF, 8'h12);
    check("rst_sig", 32'(signature), 32'(SEED));
    check("rst_busy", 32'(busy), 0);
    idle();

    // OR clean run
    go(2'd1);
    beat(0, 8'hFF, 8'h4A, 8'hFF);
    beat(0, 8'h00, 8'hFF, 8'hFF);
    beat(0, 8'h55, 8'hAA, 8'hFF);
    beat(1, 8'h84, 8'h40, 8'hC4);
    check("or_vec", 32'(vec_cnt), 4);
    check("or_err", 32'(err_cnt), 0);
    check("or_pass", 32'(pass), 1);
    check("or_done", 32'(done), 1);

    // AND fault capture, beats 2 and 4 corrupted
    go(2'd0);
    beat(0, 8'h12, 8'h34, 8'h10);
    beat(0, 8'hFF, 8'h0F, 8'h0F);
    beat(0, 8'hF0, 8'h3C, 8'h31);
    beat(0, 8'hAA, 8'h55, 8'h00);
    beat(1, 8'hC3, 8'h81, 8'h00);
    check("and_err", 32'(err_cnt), 2);
    check("and_fidx", 32'(first_err_idx), 2);
    check("and_fexp", 32'(first_err_exp), 32'h30);
    check("and_fgot", 32'(first_err_got), 32'h31);
    check("and_pass", 32'(pass), 0);

    // beats in DONE ignored, then NOR restart
    beat(0, 8'h01, 8'h02, 8'h03);
    beat(1, 8'h04, 8'h05, 8'h06);
    check("ign_vec", 32'(vec_cnt), 5);
    go(2'd3);
    beat(1, 8'h00, 8'h00, 8'hFF);
    check("nor_vec", 32'(vec_cnt), 1);
    check("nor_err", 32'(err_cnt), 0);
    check("nor_fidx", 32'(first_err_idx), 0);
    check("nor_sig", 32'(signature), 32'h00FF);

    // saturation: 20 mismatching XOR beats
    go(2'd2);
    for (int i = 0; i < 20; i++)
      beat(i == 19, 8'(i), 8'h5A, 8'(i) ^ 8'hA5);
    check("sat_vec", 32'(s_vec), 32'hF);
    check("sat_err", 32'(s_err), 32'hF);
    check("sat_fidx", 32'(s_fidx), 0);
    check("wide_vec", 32'(vec_cnt), 20);

    // mid-run reset, then a normal run
    go(2'd1);
    beat(0, 8'h11, 8'h22, 8'h33);
    beat(0, 8'h11, 8'h22, 8'h00);
    beat(0, 8'h40, 8'h01, 8'h41);
    cyc(0, 0, 2'd0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("mrst_vec", 32'(vec_cnt), 0);
    check("mrst_fgot", 32'(first_err_got), 0);
    idle();
    go(2'd2);
    beat(0, 8'h0F, 8'hF0, 8'hFF);
    beat(1, 8'h33, 8'h33, 8'h00);
    check("post_pass", 32'(pass), 1);

    // random runs with gaps, stray starts and corruption
    for (int r = 0; r < 40; r++)
      rand_run($urandom_range(1, 24));
    rand_run(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
